dff_delay_line: RTL

DFF_DELAY_LINE -- requirements
Module: dff_delay_line

---
 rtl/dff_pkg.sv | 11 +
 rtl/dff_stage_reg.sv | 38 +++
 rtl/dff_delay_line.sv | 82 ++++++++
 3 files changed

// File: rtl/dff_pkg.sv
// Shared limits and helpers for the register delay line.
package dff_pkg;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned MAX_DEPTH = 32;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage_reg.sv
// One delay-line stage: enabled register with synchronous clear and
// asynchronous active-low reset to a parameter value.
module dff_stage_reg #(
  parameter int unsigned    W       = 9,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Clear wins over enable so a flush discards the incoming word.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = RST_VAL;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/dff_delay_line.sv
// Fixed-latency register delay line carrying data plus a valid bit per stage,
// with an incrementally tracked count of valid stages.
module dff_delay_line
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          async_reset_n,
  input  logic                          en,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              d,
  output logic [WIDTH-1:0]              q,
  output logic                          q_valid,
  output logic [cnt_width(DEPTH)-1:0]   fill_count,
  output logic                          full
);

  localparam int unsigned CW = cnt_width(DEPTH);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("dff_delay_line: WIDTH out of range 1..%0d", MAX_WIDTH);
  end
  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("dff_delay_line: DEPTH out of range 1..%0d", MAX_DEPTH);
  end

  // Bit WIDTH of each stage is the valid flag, bits WIDTH-1:0 the data.
  logic [WIDTH:0] stage_q [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH:0] stage_in;
    if (i == 0) begin : g_head
      assign stage_in = {in_valid, d};
    end else begin : g_body
      assign stage_in = stage_q[i-1];
    end

    dff_stage_reg #(
      .W       (WIDTH + 1),
      .RST_VAL ({1'b0, RESET_VALUE})
    ) u_stage (
      .clk_i  (clk),
      .rst_ni (async_reset_n),
      .en_i   (en),
      .clr_i  (clear),
      .d_i    (stage_in),
      .q_o    (stage_q[i])
    );
  end

  assign q       = stage_q[DEPTH-1][WIDTH-1:0];
  assign q_valid = stage_q[DEPTH-1][WIDTH];

  logic [CW-1:0] fill_q;
  logic [CW-1:0] fill_d;

  // Modular add/subtract is exact: the true result always lies in 0..DEPTH.
  always_comb begin
    fill_d = fill_q;
    if (clear) begin
      fill_d = '0;
    end else if (en) begin
      fill_d = fill_q + CW'(in_valid) - CW'(q_valid);
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill_count = fill_q;
  assign full       = (fill_q == CW'(DEPTH));

endmodule
